// File: rtl/ycchain_loader.sv
// ycchain_loader
//   Drives the 3-bit-per-cell configuration shift chain of a row of yellow
//   cells. It takes one 3-bit cell code per valid/ready handshake and shifts
//   it out MSB-first on cbitout, using a confclk generated from clk. The array
//   is held in reset while a frame loads.
//
//   Optional feature (macro YCCHAIN_READBACK_EN): the bits leaving the chain
//   tail on cbitin are captured and presented as rb_code with an rb_valid
//   strobe, one per cell. Without the macro those ports are absent and
//   cbitin is ignored.
//
// Parameters
//   CELLS  number of cells; one frame = CELLS codes
//   DIV    clk cycles per confclk phase (1..255)
//
// Ports
//   clk, reset        system clock, async active-high reset
//   start             begin a frame (sampled in IDLE only)
//   code/code_valid/code_ready   host code handshake
//   confclk, cbitout  chain shift clock and serial data out
//   cbitin            serial data returning from the chain tail
//   array_reset       yellow-cell reset, high while unconfigured or loading
//   busy, done        frame in progress / one-cycle completion pulse
//   rb_code, rb_valid readback code and strobe (macro builds only)
module ycchain_loader #(
  parameter int unsigned CELLS = 16,
  parameter int unsigned DIV   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       confclk,
  output logic       cbitout,
  input  logic       cbitin,
  output logic       array_reset,
  output logic       busy,
  output logic       done
`ifdef YCCHAIN_READBACK_EN
  ,
  output logic [2:0] rb_code,
  output logic       rb_valid
`endif
);

  localparam int unsigned CNT_W = $clog2(CELLS + 1);
  localparam logic [7:0] PHASE_LOAD = 8'(DIV - 1);
  localparam logic [CNT_W-1:0] LAST_CODE = CNT_W'(CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CODE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       shreg_q, shreg_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] code_cnt_q, code_cnt_d;
  logic [7:0]       timer_q, timer_d;
  logic             phase_end;

  logic code_ready_q, code_ready_d;
  logic confclk_q, confclk_d;
  logic cbitout_q, cbitout_d;
  logic array_reset_q, array_reset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign phase_end = (timer_q == 8'd0);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shreg_q       <= 3'b000;
      bit_cnt_q     <= 2'd0;
      code_cnt_q    <= '0;
      timer_q       <= 8'd0;
      code_ready_q  <= 1'b0;
      confclk_q     <= 1'b0;
      cbitout_q     <= 1'b0;
      array_reset_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      code_cnt_q    <= code_cnt_d;
      timer_q       <= timer_d;
      code_ready_q  <= code_ready_d;
      confclk_q     <= confclk_d;
      cbitout_q     <= cbitout_d;
      array_reset_q <= array_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next state; timer is a down-counter reloaded on every phase entry
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    code_cnt_d = code_cnt_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_CODE;
          code_cnt_d = '0;
        end
      end
      S_WAIT_CODE: begin
        if (code_valid && code_ready_q) begin
          shreg_d   = code;
          bit_cnt_d = 2'd2;
          timer_d   = PHASE_LOAD;
          state_d   = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          timer_d = PHASE_LOAD;
          state_d = S_SHIFT_HI;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          shreg_d = {shreg_q[1:0], 1'b0};
          if (bit_cnt_q != 2'd0) begin
            bit_cnt_d = bit_cnt_q - 2'd1;
            timer_d   = PHASE_LOAD;
            state_d   = S_SHIFT_LO;
          end else begin
            code_cnt_d = code_cnt_q + CNT_W'(1);
            state_d    = (code_cnt_q == LAST_CODE) ? S_FINISH : S_WAIT_CODE;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one changes only on clk
  always_comb begin
    code_ready_d = (state_d == S_WAIT_CODE);
    confclk_d    = (state_d == S_SHIFT_HI);
    busy_d       = (state_d == S_WAIT_CODE) || (state_d == S_SHIFT_LO) ||
                   (state_d == S_SHIFT_HI);
    done_d       = (state_d == S_FINISH);
    // cbitout only moves on entry to SHIFT_LO, giving DIV cycles of setup
    // before and DIV cycles of hold after each confclk rising edge.
    cbitout_d    = cbitout_q;
    if ((state_d == S_SHIFT_LO) && (state_q != S_SHIFT_LO)) begin
      cbitout_d = shreg_d[2];
    end
    array_reset_d = array_reset_q;
    if ((state_q == S_IDLE) && (state_d == S_WAIT_CODE)) begin
      array_reset_d = 1'b1;
    end else if (state_d == S_FINISH) begin
      array_reset_d = 1'b0;
    end
  end

  assign code_ready  = code_ready_q;
  assign confclk     = confclk_q;
  assign cbitout     = cbitout_q;
  assign array_reset = array_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef YCCHAIN_READBACK_EN
  logic [2:0] rb_shift_q, rb_shift_d;
  logic [2:0] rb_code_q, rb_code_d;
  logic       rb_valid_q, rb_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_shift_q <= 3'b000;
      rb_code_q  <= 3'b000;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_code_q  <= rb_code_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Tail bit is sampled in the last low cycle, before the chain shifts.
  // The strobe lands in the same cycle the FSM returns to WAIT_CODE/FINISH.
  always_comb begin
    rb_shift_d = rb_shift_q;
    if ((state_q == S_SHIFT_LO) && phase_end) begin
      rb_shift_d = {rb_shift_q[1:0], cbitin};
    end
    rb_valid_d = (state_q == S_SHIFT_HI) && phase_end && (bit_cnt_q == 2'd0);
    rb_code_d  = rb_valid_d ? rb_shift_q : rb_code_q;
  end

  assign rb_code  = rb_code_q;
  assign rb_valid = rb_valid_q;
`else
  logic cbitin_unused;
  assign cbitin_unused = cbitin;
`endif

endmodule

// File: doc/ycchain_loader.md
# ycchain_loader

Configuration loader that sits directly upstream of a chain of yellow cells and drives the 3-bit-per-cell configuration shift chain. It accepts one 3-bit cell code per valid/ready handshake from a host and serialises each code MSB-first onto the chain's `cbitin`. It generates the chain's `confclk` from the system clock and holds the array in `reset` while a frame is loading. Optionally, it captures the old configuration as it shifts out of the chain tail.

## Interface
- `CELLS`, 16: number of yellow cells in the chain; a frame is exactly `CELLS` codes, or `3*CELLS` bits.
- `DIV`, 1: length of each `confclk` phase in `clk` cycles; range 1..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `code`  in  3  cell configuration code; the first code accepted lands in the cell farthest from the loader.
- `code_valid`  in  1  host has a code on `code`.
- `code_ready`  out  1  loader accepts `code` this cycle.
- `confclk`  out  1  chain shift clock; registered, glitch-free.
- `cbitout`  out  1  serial data to the first cell's `cbitin`.
- `cbitin`  in  1  serial data from the last cell's `cbitout`; used for readback.
- `array_reset`  out  1  drives the yellow-cell `reset`; high while unconfigured or loading.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `rb_code`  out  3  readback code; exists only with the macro enabled.
- `rb_valid`  out  1  one-cycle strobe qualifying `rb_code`; exists only with the macro enabled.

## Operation
- States:
  - IDLE → WAIT_CODE → SHIFT_LO → SHIFT_HI, looping back to SHIFT_LO or WAIT_CODE.
  - From the last SHIFT_HI of the frame → FINISH → IDLE.
- IDLE:
  - Outputs: `busy`=0, `code_ready`=0.
  - `start`=1 → WAIT_CODE, `busy`=1, `array_reset`=1, code counter cleared.
- WAIT_CODE:
  - `code_ready`=1.
  - On `code_valid`&`code_ready`, the loader latches `code` into a 3-bit shift register, sets the bit counter to 2, and goes to SHIFT_LO.
  - `code_valid` low → remain; there is no timeout.
- SHIFT_LO:
  - `cbitout` = current MSB, `confclk`=0, held for `DIV` cycles, then → SHIFT_HI.
- SHIFT_HI:
  - `confclk`=1 for `DIV` cycles; the cells shift on this rising edge.
  - `cbitout` is held stable through the whole phase.
  - At phase end, the loader shifts its register left.
  - If bits remain → SHIFT_LO.
  - Otherwise the code counter increments. If the count is less than `CELLS` → WAIT_CODE; if it equals `CELLS` → FINISH.
- FINISH:
  - `done`=1 for one cycle, `array_reset`=0, `busy`=0, → IDLE.
- Bit order: `code[2]`, `code[1]`, `code[0]`. After the frame, cell k (0 = nearest) holds the code accepted at position `CELLS-1-k`.
- `array_reset` stays low after a successful frame until the next `start` or `reset`.
- `start` while `busy` is ignored.
- `code_valid` outside WAIT_CODE is ignored. `code` is not consumed.

## Timing
- Reset values:
  - state IDLE.
  - `confclk`=0, `cbitout`=0, `code_ready`=0, `busy`=0, `done`=0.
  - `array_reset`=1.
  - `rb_code`=0, `rb_valid`=0.
- All outputs are registered. Each output changes only on the `clk` rising edge, except during asynchronous reset.
- Per code: 1 handshake cycle (minimum) plus `6*DIV` shift cycles.
- Minimum frame, with `code_valid` always high: 1 (start) + `CELLS*(1+6*DIV)` + 1 (FINISH) cycles.
- The `confclk` rising edge occurs exactly `DIV` cycles after `cbitout` changes. `cbitout` changes only on entry to SHIFT_LO, so there is setup and hold of `DIV` cycles on both sides of the rising edge.
- Reset mid-frame:
  - `confclk` is forced low immediately, with no runt high pulse beyond the asynchronous clear.
  - The partial chain contents are undefined. `array_reset`=1. Software must reload.

## Configuration
- `YCCHAIN_READBACK_EN` defined:
  - The loader samples `cbitin` in the last cycle of each SHIFT_LO, before the rising edge, into a 3-bit register.
  - After every third bit, it presents that register on `rb_code` with a one-cycle `rb_valid` pulse in the same cycle as the return to WAIT_CODE or FINISH.
  - Codes emerge farthest cell first, reproducing the previous frame's accept order. This allows load-and-verify.
- Not defined:
  - The `rb_code`/`rb_valid` ports are absent.
  - `cbitin` is unused.
  - Port lists and widths are otherwise identical.

## Test plan
- Reset: `CELLS`=4, `DIV`=1, reset asserted → all outputs at reset values. `array_reset`=1 and `confclk`=0 during and after reset.
- Basic load: start, codes 3'b001, 3'b010, 3'b011, 3'b100, `code_valid` always high → `cbitout` sequence 001 010 011 100 on 12 `confclk` rising edges. `done` pulses at cycle 1+4*7+1=30 after start. `array_reset` falls with `done`. A model chain then holds cells 0..3 = 100, 011, 010, 001.
- Back-pressure and DIV: `DIV`=3, `code_valid` low for 5 cycles before the second code → `code_ready` stays high with no `confclk` activity. Each `confclk` phase lasts 3 cycles and `cbitout` is stable across every rising edge.
- Reset mid-frame: reset asserted during SHIFT_HI of code 2 → `confclk` drops to 0 asynchronously, state IDLE, `busy`=0, `array_reset`=1. A new start loads cleanly.
- Ignored events: `start` pulsed while `busy`, and `code_valid` in IDLE → no new frame, no code consumed, bit count unchanged.
- Readback (macro on): a second frame after loading 001, 010, 011, 100 → `rb_code` strobes 001, 010, 011, 100, one per code, each with a single-cycle `rb_valid`.
